// File: rtl/reg_rr_arbiter_if.sv
// Requester-side bundle for the shared-register round-robin arbiter.
// The lock vector exists only when ARB_LOCK_EN is defined.
interface reg_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] wr_data;
`ifdef ARB_LOCK_EN
  logic [NUM_REQ-1:0]        lock;
`endif
  logic [NUM_REQ-1:0]        gnt;
  logic [DATA_W-1:0]         q;
  logic                      q_valid;
  logic [IW-1:0]             q_owner;

  modport master (
    output req,
    output wr_data,
`ifdef ARB_LOCK_EN
    output lock,
`endif
    input  gnt,
    input  q,
    input  q_valid,
    input  q_owner
  );

  modport slave (
    input  req,
    input  wr_data,
`ifdef ARB_LOCK_EN
    input  lock,
`endif
    output gnt,
    output q,
    output q_valid,
    output q_owner
  );
endinterface

// File: rtl/reg_rr_arbiter.sv
// Round-robin arbiter owning one enable-gated data register.
// Define ARB_LOCK_EN to let a granted owner hold the register for bursts.
module reg_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic           clk,
  input  logic           rst,
  reg_rr_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

  typedef enum logic {IDLE, ACK} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       owner;
  logic [IW-1:0]       win;
  logic [IW-1:0]       idx;
  logic                found;
  logic [DATA_W-1:0]   q_r;
  logic [DATA_W-1:0]   wdata;
  logic [NUM_REQ-1:0]  ack_vec;
  logic [NUM_REQ-1:0]  req_eff;

  assign ack_vec = (state == ACK)
                 ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << owner)
                 : '0;
  assign req_eff = bus.req & ~ack_vec;

  // Search starts one past the last winner; wrap is explicit so that
  // non power-of-two NUM_REQ never indexes a missing requester.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (idx == LAST) ? '0 : idx + 1'b1;
      if (!found && req_eff[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
`ifdef ARB_LOCK_EN
    if (state == ACK && bus.lock[owner] && bus.req[owner]) begin
      found = 1'b1;
      win   = owner;
    end
`endif
    state_nxt = found ? ACK : IDLE;
  end

  always_comb begin
    wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == IW'(i))
        wdata = bus.wr_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= LAST;
      owner <= '0;
      q_r   <= '0;
    end else begin
      state <= state_nxt;
      if (found) begin
        q_r   <= wdata;
        owner <= win;
        ptr   <= win;
      end
    end
  end

  assign bus.gnt     = rst ? '0 : ack_vec;
  assign bus.q       = q_r;
  assign bus.q_valid = (state == ACK);
  assign bus.q_owner = owner;
endmodule

// File: tb/tb_reg_rr_arbiter.sv
// Directed bench for reg_rr_arbiter with a per-cycle reference model.
// Define ARB_LOCK_EN to also exercise lock bursts.
module tb_reg_rr_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_rr_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus();

  reg_rr_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit live = 1'b0;
  bit auto_drop = 1'b1;

  int m_ptr   = N - 1;
  int m_owner = 0;
  int m_q     = 0;
  bit m_ack   = 1'b0;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: scan requesters after the pointer, skipping the one
  // currently acknowledged; a locked owner wins outright.
  always @(posedge clk) begin
    int win;
    if (rst) begin
      m_ptr = N - 1; m_owner = 0; m_q = 0; m_ack = 1'b0;
    end else begin
      win = -1;
`ifdef ARB_LOCK_EN
      if (m_ack && bus.lock[m_owner] && bus.req[m_owner]) win = m_owner;
`endif
      if (win < 0) begin
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (bus.req[j] && !(m_ack && m_owner == j)) begin
            win = j;
            break;
          end
        end
      end
      if (win >= 0) begin
        m_q = int'(bus.wr_data[win*W +: W]);
        m_owner = win; m_ptr = win; m_ack = 1'b1;
      end else begin
        m_ack = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("model_gnt", int'(bus.gnt),
          (m_ack && !rst) ? (1 << m_owner) : 0);
      chk("model_q", int'(bus.q), m_q);
      chk("model_valid", int'(bus.q_valid), int'(m_ack));
      chk("model_owner", int'(bus.q_owner), m_owner);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_drop) bus.req = bus.req & ~bus.gnt;
  endtask

  initial begin
    bus.req = '0;
    bus.wr_data = '0;
`ifdef ARB_LOCK_EN
    bus.lock = '0;
`endif
    @(posedge clk);
    #1;
    live = 1'b1;

    bus.req = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_q", int'(bus.q), 0);
      chk("rst_gnt", int'(bus.gnt), 0);
      chk("rst_valid", int'(bus.q_valid), 0);
      chk("rst_owner", int'(bus.q_owner), 0);
    end
    bus.req = '0;
    rst = 1'b0;

    bus.wr_data[7:0] = 8'hA5;
    bus.req = 4'b0001;
    tick();
    chk("single_q", int'(bus.q), 'hA5);
    chk("single_gnt", int'(bus.gnt), 1);
    chk("single_valid", int'(bus.q_valid), 1);
    chk("single_owner", int'(bus.q_owner), 0);
    tick();
    chk("single_gnt_clr", int'(bus.gnt), 0);
    chk("single_valid_clr", int'(bus.q_valid), 0);
    chk("single_q_hold", int'(bus.q), 'hA5);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.wr_data = 32'h44332211;
    bus.req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("all_gnt", int'(bus.gnt), 1 << k);
      chk("all_q", int'(bus.q), (k + 1) * 'h11);
    end
    tick();
    chk("all_idle", int'(bus.q_valid), 0);

    auto_drop = 1'b0;
    bus.req = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("fair_owner", int'(bus.q_owner), (k % 2) * 2);
    end
    bus.req = '0;
    tick();

    bus.req = 4'b1111;
    tick();
    chk("midrst_pre_gnt", int'(bus.gnt), 4'b1000);
    rst = 1'b1;
    tick();
    chk("midrst_q", int'(bus.q), 0);
    chk("midrst_gnt", int'(bus.gnt), 0);
    chk("midrst_valid", int'(bus.q_valid), 0);
    chk("midrst_owner", int'(bus.q_owner), 0);
    rst = 1'b0;
    tick();
    chk("midrst_first_gnt", int'(bus.gnt), 1);
    bus.req = '0;
    tick();
    tick();

`ifdef ARB_LOCK_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.wr_data = 32'h00009901;
    bus.req = 4'b0011;
    bus.lock = 4'b0001;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("lock_gnt", int'(bus.gnt), 1);
      chk("lock_q", int'(bus.q), k);
      bus.wr_data[7:0] = 8'(k + 1);
    end
    bus.lock = '0;
    tick();
    chk("unlock_gnt", int'(bus.gnt), 4'b0010);
    chk("unlock_q", int'(bus.q), 'h99);
    bus.req = '0;
    tick();
    tick();
`endif

    @(negedge clk);
    live = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
